// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [15:0] TXDATA_OFS = 16'd0;
  localparam logic [15:0] STATUS_OFS = 16'd4;

  localparam int FULL  = 0;
  localparam int EMPTY = 1;
  localparam int BUSY  = 2;
  localparam int OVF   = 3;

  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic busy, input logic ovf);
    logic [31:0] w;
    w       = '0;
    w[FULL]  = full;
    w[EMPTY] = empty;
    w[BUSY]  = busy;
    w[OVF]   = ovf;
    return w;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO with first-word fall-through output so the consumer
// can load dout on the same edge it pops.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     key,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push_ok;
  logic          pop_ok;

  // Full/empty come from the pre-edge count, so a push while full is dropped
  // even when a pop happens in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (key) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a byte FIFO, the FSM
// drains it LSB first on tx, STATUS reports FIFO/line state and overflow.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] BASE_ADDR    = 16'hFF00
) (
  input  logic        clk,
  input  logic        key,
  input  logic        en,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int          BW          = $clog2(CLKS_PER_BIT);
  localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [15:0] TXDATA_ADDR = BASE_ADDR + TXDATA_OFS;
  localparam logic [15:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;

  tx_state_e     state_reg;
  logic [BW-1:0] baud_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;
  logic          busy_reg;
  logic          overflow_reg;

  logic          wr_txdata;
  logic          wr_status;
  logic          push_ok;
  logic          pop_req;
  logic          baud_end;
  logic          idle_next;
  logic          fifo_empty_next;
  logic          busy_next;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_wdata;

  assign wr_txdata    = en && (addr == TXDATA_ADDR);
  assign wr_status    = en && (addr == STATUS_ADDR);
  assign push_ok      = wr_txdata && !fifo_full;
  assign baud_end     = (baud_reg == BAUD_LAST);
  assign pop_req      = !fifo_empty && ((state_reg == IDLE) || ((state_reg == STOP) && baud_end));
  assign unused_wdata = ^wdata[31:8];

  // busy tracks next-state values so it drops on the edge the line goes idle.
  assign idle_next       = fifo_empty && ((state_reg == IDLE) || ((state_reg == STOP) && baud_end));
  assign fifo_empty_next = fifo_empty ? !push_ok
                                      : ((fifo_count == CW'(1)) && pop_req && !push_ok);
  assign busy_next       = !idle_next || !fifo_empty_next;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .key   (key),
    .push  (wr_txdata),
    .pop   (pop_req),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (key) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      case (state_reg)
        IDLE: begin
          if (pop_req) begin
            shift_reg <= fifo_dout;
            tx_reg    <= 1'b0;
            baud_reg  <= '0;
            state_reg <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_reg    <= '0;
            tx_reg      <= shift_reg[0];
            bit_idx_reg <= '0;
            state_reg   <= DATA;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_reg  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_idx_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= STOP;
            end else begin
              tx_reg      <= shift_reg[1];
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_reg <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (pop_req) begin
              shift_reg <= fifo_dout;
              tx_reg    <= 1'b0;
              state_reg <= START;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  // A new overflow in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (key) begin
      overflow_reg <= 1'b0;
    end else if (wr_txdata && fifo_full) begin
      overflow_reg <= 1'b1;
    end else if (wr_status && wdata[3]) begin
      overflow_reg <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (addr == STATUS_ADDR) begin
      rdata = status_word(fifo_full, fifo_empty, state_reg != IDLE, overflow_reg);
    end
  end

  assign tx   = tx_reg;
  assign busy = busy_reg;

endmodule
